// File: rtl/array_feeder_if.sv
// Load port, job control and array-edge bundle for array_feeder.
// The master side loads rows and starts jobs; the slave side is the feeder.
interface array_feeder_if #(
    parameter int BW = 16
);
    logic                 ld_valid;
    logic                 ld_ready;
    logic                 ld_sel;
    logic [1:0]           ld_idx;
    logic [4*BW-1:0]      ld_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic signed [BW-1:0] west_in [4];
    logic signed [BW-1:0] north_in [4];
    logic [3:0]           west_vld;
    logic [3:0]           north_vld;
    logic                 acc_clr;
    logic                 out_phase;
    logic [15:0]          job_cnt;

    modport master (
        output ld_valid, ld_sel, ld_idx, ld_data, start,
        input  ld_ready, busy, done, west_in, north_in,
        input  west_vld, north_vld, acc_clr, out_phase, job_cnt
    );

    modport slave (
        input  ld_valid, ld_sel, ld_idx, ld_data, start,
        output ld_ready, busy, done, west_in, north_in,
        output west_vld, north_vld, acc_clr, out_phase, job_cnt
    );
endinterface

// File: rtl/array_feeder.sv
// Skewed operand feeder for a 4x4 systolic array with A/B row banks.
// Define ARRAY_FEEDER_STAT_EN to enable the completed-job counter job_cnt.
module array_feeder #(
    parameter int BW        = 16,
    parameter int FLUSH_CYC = 4,
    parameter int DRAIN_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    array_feeder_if.slave f
);
    typedef enum logic [2:0] {
        IDLE, CLR, FEED, FLUSH, DRAIN, DONE
    } state_t;

    state_t               state;
    logic [2:0]           beat;
    logic [7:0]           cnt;
    logic signed [BW-1:0] a [4][4];
    logic signed [BW-1:0] b [4][4];

    logic                 busy_q;
    logic                 done_q;
    logic                 clr_q;
    logic                 oph_q;
    logic signed [BW-1:0] west_q [4];
    logic signed [BW-1:0] north_q [4];
    logic [3:0]           wv_q;
    logic [3:0]           nv_q;

    logic                 wr;
    logic                 feed_ld;
    logic [2:0]           nb;
    logic signed [BW-1:0] west_n [4];
    logic signed [BW-1:0] north_n [4];
    logic [3:0]           wv_n;
    logic [3:0]           nv_n;

    assign wr = f.ld_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                for (int k = 0; k < 4; k++) begin
                    a[r][k] <= '0;
                    b[r][k] <= '0;
                end
            end
        end else if (wr) begin
            for (int k = 0; k < 4; k++) begin
                if (f.ld_sel)
                    b[f.ld_idx][k] <= f.ld_data[k*BW +: BW];
                else
                    a[f.ld_idx][k] <= f.ld_data[k*BW +: BW];
            end
        end
    end

    // Operands for the next beat: row r / column c sees element k when t == r + k.
    always_comb begin
        feed_ld = (state == CLR) || ((state == FEED) && (beat != 3'd6));
        nb      = (state == CLR) ? 3'd0 : beat + 3'd1;
        wv_n    = '0;
        nv_n    = '0;
        for (int r = 0; r < 4; r++) begin
            west_n[r]  = '0;
            north_n[r] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                if ({1'b0, nb} == 4'(r + k)) begin
                    west_n[r]  = a[r][k];
                    north_n[r] = b[k][r];
                    wv_n[r]    = 1'b1;
                    nv_n[r]    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !feed_ld) begin
            wv_q <= '0;
            nv_q <= '0;
            for (int r = 0; r < 4; r++) begin
                west_q[r]  <= '0;
                north_q[r] <= '0;
            end
        end else begin
            wv_q <= wv_n;
            nv_q <= nv_n;
            for (int r = 0; r < 4; r++) begin
                west_q[r]  <= west_n[r];
                north_q[r] <= north_n[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            oph_q  <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (f.start) begin
                        state  <= CLR;
                        busy_q <= 1'b1;
                        clr_q  <= 1'b1;
                    end
                end
                CLR: begin
                    state <= FEED;
                    beat  <= '0;
                end
                FEED: begin
                    if (beat == 3'd6) begin
                        state <= FLUSH;
                        cnt   <= 8'(FLUSH_CYC - 1);
                    end else begin
                        beat <= beat + 3'd1;
                    end
                end
                FLUSH: begin
                    if (cnt == 8'd0) begin
                        state <= DRAIN;
                        cnt   <= 8'(DRAIN_CYC - 1);
                        oph_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DRAIN: begin
                    if (cnt == 8'd0) begin
                        state  <= DONE;
                        oph_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARRAY_FEEDER_STAT_EN
    logic [15:0] jc_q;

    always_ff @(posedge clk) begin
        if (rst)
            jc_q <= '0;
        else if ((state == DRAIN) && (cnt == 8'd0))
            jc_q <= jc_q + 16'd1;
    end

    assign f.job_cnt = jc_q;
`else
    assign f.job_cnt = '0;
`endif

    assign f.ld_ready  = (state == IDLE);
    assign f.busy      = busy_q;
    assign f.done      = done_q;
    assign f.acc_clr   = clr_q;
    assign f.out_phase = oph_q;
    assign f.west_vld  = wv_q;
    assign f.north_vld = nv_q;
    assign f.west_in   = west_q;
    assign f.north_in  = north_q;
endmodule

// File: tb/tb_array_feeder.sv
// Scoreboard bench for array_feeder: per-cycle expected records are queued
// at job start and compared against the DUT every cycle of the job.
module tb_array_feeder;
    localparam int BW = 16;
    localparam int F  = 4;
    localparam int D  = 16;
    localparam int L  = 9 + F + D;

    typedef struct packed {
        logic            busy;
        logic            rdy;
        logic            clr;
        logic            oph;
        logic            done;
        logic [3:0]      wv;
        logic [3:0]      nv;
        logic [4*BW-1:0] w;
        logic [4*BW-1:0] n;
        logic [15:0]     jc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    array_feeder_if #(.BW(BW)) f();

    array_feeder #(
        .BW(BW), .FLUSH_CYC(F), .DRAIN_CYC(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .f(f)
    );

    always #5 clk = ~clk;

    logic signed [BW-1:0] ma [4][4];
    logic signed [BW-1:0] mb [4][4];
    logic [15:0]          exp_jc;
    rec_t                 sb [$];
    int                   n_tests = 0;
    int                   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t obs();
        rec_t o;
        o.busy = f.busy;
        o.rdy  = f.ld_ready;
        o.clr  = f.acc_clr;
        o.oph  = f.out_phase;
        o.done = f.done;
        o.wv   = f.west_vld;
        o.nv   = f.north_vld;
        for (int i = 0; i < 4; i++) begin
            o.w[i*BW +: BW] = f.west_in[i];
            o.n[i*BW +: BW] = f.north_in[i];
        end
        o.jc = f.job_cnt;
        return o;
    endfunction

    function automatic rec_t idle_rec(input logic [15:0] jc);
        rec_t e;
        e     = '0;
        e.rdy = 1'b1;
`ifdef ARRAY_FEEDER_STAT_EN
        e.jc  = jc;
`else
        e.jc  = 16'd0 & jc;
`endif
        return e;
    endfunction

    // Expected outputs k cycles after the cycle in which start was sampled.
    function automatic rec_t exp_at(input int k);
        rec_t e;
        int   t;
        int   d;
        e      = '0;
        e.busy = (k >= 1) && (k <= L);
        e.rdy  = !e.busy;
        e.clr  = (k == 1);
        e.oph  = (k >= 9 + F) && (k <= 8 + F + D);
        e.done = (k == L);
        if (k >= 2 && k <= 8) begin
            t = k - 2;
            for (int r = 0; r < 4; r++) begin
                d = t - r;
                if (d >= 0 && d <= 3) begin
                    e.w[r*BW +: BW] = ma[r][d];
                    e.wv[r]         = 1'b1;
                    e.n[r*BW +: BW] = mb[d][r];
                    e.nv[r]         = 1'b1;
                end
            end
        end
`ifdef ARRAY_FEEDER_STAT_EN
        e.jc = (k >= L) ? exp_jc + 16'd1 : exp_jc;
`else
        e.jc = 16'd0;
`endif
        return e;
    endfunction

    task automatic load_row(input logic sel, input logic [1:0] idx,
                            input logic [4*BW-1:0] data);
        f.ld_valid = 1'b1;
        f.ld_sel   = sel;
        f.ld_idx   = idx;
        f.ld_data  = data;
        for (int k = 0; k < 4; k++) begin
            if (sel) mb[idx][k] = data[k*BW +: BW];
            else     ma[idx][k] = data[k*BW +: BW];
        end
    endtask

    // Starts a job in the current cycle and scoreboards it through one idle cycle.
    // inj_start_k / inj_ld_k inject a stray start / row write in that cycle.
    task automatic run_job(input int inj_start_k, input int inj_ld_k);
        rec_t e;
        rec_t o;
        for (int k = 1; k <= L + 1; k++) sb.push_back(exp_at(k));
        f.start = 1'b1;
        tick();
        f.start    = 1'b0;
        f.ld_valid = 1'b0;
        for (int k = 1; k <= L + 1; k++) begin
            e = sb.pop_front();
            o = obs();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb k=%0d got %h exp %h", k, o, e);
            end
            f.start = (k == inj_start_k);
            if (k == inj_ld_k) begin
                f.ld_valid = 1'b1;
                f.ld_sel   = 1'b0;
                f.ld_idx   = 2'd0;
                f.ld_data  = {4{16'h7777}};
                n_tests++;
                if (f.ld_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ld_ready_busy got %b exp 0", f.ld_ready);
                end
            end
            tick();
            f.start    = 1'b0;
            f.ld_valid = 1'b0;
        end
        exp_jc = exp_jc + 16'd1;
    endtask

    task automatic test_reset();
        rec_t o;
        rst = 1'b1;
        tick();
        tick();
        o = obs();
        n_tests++;
        if (o !== idle_rec(16'd0)) begin
            n_fail++;
            $display("FAIL reset got %h exp %h", o, idle_rec(16'd0));
        end
        rst = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                ma[r][k] = '0;
                mb[r][k] = '0;
            end
        exp_jc = 16'd0;
        tick();
    endtask

    task automatic test_identity();
        logic [4*BW-1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = '0;
            v[i*BW +: BW] = 16'd1;
            load_row(1'b0, 2'(i), v);
            tick();
            for (int j = 0; j < 4; j++) v[j*BW +: BW] = 16'(4 * i + j + 1);
            load_row(1'b1, 2'(i), v);
            tick();
        end
        f.ld_valid = 1'b0;
        tick();
        run_job(0, 0);
    endtask

    task automatic test_random();
        logic [4*BW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) v[j*BW +: BW] = 16'($urandom);
            load_row(i[0], 2'(i >> 1), v);
            tick();
        end
        f.ld_valid = 1'b0;
        run_job(0, 0);
    endtask

    task automatic test_ignore();
        run_job(5, 9 + F + 1);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (f.busy !== 1'b0 || f.ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL no_second_job busy=%b rdy=%b exp 0/1",
                         f.busy, f.ld_ready);
            end
            tick();
        end
        run_job(0, 0);
    endtask

    task automatic test_same_cycle();
        logic [4*BW-1:0] v;
        for (int j = 0; j < 4; j++) v[j*BW +: BW] = 16'(16'h0A00 + j);
        load_row(1'b1, 2'd2, v);
        run_job(0, 0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            run_job(0, 0);
            n_tests++;
`ifdef ARRAY_FEEDER_STAT_EN
            if (f.job_cnt !== exp_jc) begin
                n_fail++;
                $display("FAIL job_cnt got %0d exp %0d", f.job_cnt, exp_jc);
            end
`else
            if (f.job_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL job_cnt got %0d exp 0", f.job_cnt);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        rec_t o;
        f.start = 1'b1;
        tick();
        f.start = 1'b0;
        for (int k = 1; k < 11 + F; k++) tick();
        n_tests++;
        if (f.out_phase !== 1'b1) begin
            n_fail++;
            $display("FAIL drain3 out_phase got %b exp 1", f.out_phase);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = obs();
        n_tests++;
        if (o !== idle_rec(16'd0)) begin
            n_fail++;
            $display("FAIL mid_reset got %h exp %h", o, idle_rec(16'd0));
        end
        for (int i = 0; i < D + 4; i++) begin
            tick();
            n_tests++;
            if (f.done !== 1'b0 || f.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL aborted done=%b busy=%b exp 0/0",
                         f.done, f.busy);
            end
        end
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                ma[r][k] = '0;
                mb[r][k] = '0;
            end
        exp_jc = 16'd0;
        run_job(0, 0);
    endtask

    initial begin
        f.ld_valid = 1'b0;
        f.ld_sel   = 1'b0;
        f.ld_idx   = 2'd0;
        f.ld_data  = '0;
        f.start    = 1'b0;
        test_reset();
        test_identity();
        test_random();
        test_ignore();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
